bcd_updown_counter_n: RTL

- Parametrised multi-digit modulo up/down counter with synchronous load, enable, stop-at-terminal mode and wrap/terminal flags.
- Generalises the team's single-digit mod-10 up/down loadable counter to DIGITS cascaded digits of modulus MOD.
- Used as the time-base and event counter in display and timer datapaths; output digits drive per-digit 7-segment decoders directly.

---
 rtl/bcd_updown_counter_n.sv | 102 ++++++++++
 1 files changed

// File: rtl/bcd_updown_counter_n.sv
// Multi-digit modulo-MOD up/down counter with load, stop-at-terminal mode and wrap/done flags.
// Optional match compare output is enabled by defining BCD_UPDOWN_COUNTER_MATCH_EN.
module bcd_updown_counter_n #(
    parameter int DIGITS = 2,
    parameter int MOD    = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  mode_stop,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  wrap,
    output logic                  done
`ifdef BCD_UPDOWN_COUNTER_MATCH_EN
    ,
    input  logic [4*DIGITS-1:0]   match_value,
    output logic                  match
`endif
);

    localparam logic [3:0] MAX_DIGIT = 4'(MOD - 1);

    logic [4*DIGITS-1:0] q_step;
    logic [4*DIGITS-1:0] load_clamped;
    logic [3:0]          digit;
    logic                chain;
    logic                hold_stop;

    // The carry/borrow chain doubles as the terminal detector: it survives to the
    // end only when every digit sits at the terminal for the current direction.
    always_comb begin
        q_step = q;
        digit  = 4'd0;
        chain  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            digit = q[4*i +: 4];
            if (chain) begin
                if (up)
                    q_step[4*i +: 4] = (digit == MAX_DIGIT) ? 4'd0 : digit + 4'd1;
                else
                    q_step[4*i +: 4] = (digit == 4'd0) ? MAX_DIGIT : digit - 4'd1;
            end
            chain = chain & (digit == (up ? MAX_DIGIT : 4'd0));
        end
    end

    always_comb begin
        load_clamped = load_value;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_value[4*i +: 4] > MAX_DIGIT)
                load_clamped[4*i +: 4] = MAX_DIGIT;
        end
    end

    assign tc        = chain;
    assign hold_stop = chain & mode_stop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q    <= '0;
            wrap <= 1'b0;
            done <= 1'b0;
        end else if (load) begin
            q    <= load_clamped;
            wrap <= 1'b0;
            done <= 1'b0;
        end else if (enable) begin
            if (hold_stop) begin
                wrap <= 1'b0;
                done <= 1'b1;
            end else begin
                q    <= q_step;
                wrap <= chain;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

`ifdef BCD_UPDOWN_COUNTER_MATCH_EN
    logic [4*DIGITS-1:0] q_next;
    logic                moved;

    // Only edges that actually write q may raise match, so holding never re-pulses.
    always_comb begin
        moved  = load | (enable & ~hold_stop);
        q_next = load ? load_clamped : q_step;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            match <= 1'b0;
        else
            match <= moved & (q_next == match_value);
    end
`endif

endmodule
